led_ctrl_fsm_multi: RTL

//   Multi-channel successor of the single-key LED control FSM. Each channel takes a
//   one-cycle key_touch pulse and steps its LED through OFF -> ON -> BLINK -> OFF.

---
 rtl/led_ctrl_pkg.sv | 24 ++
 rtl/led_ctrl_chan.sv | 108 ++++++++++
 rtl/led_ctrl_fsm_multi.sv | 51 +++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_ctrl_pkg
//   Types and helpers shared by the multi-channel LED controller.
//   - led_state_e : per-channel state encoding (OFF/ON/BLINK; code 11 is
//                   illegal and is recovered to OFF)
//   - cnt_w()     : counter width for a counter whose largest value is n-1,
//                   never less than one bit
// -----------------------------------------------------------------------------
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ON    = 2'b01,
    ST_BLINK = 2'b10,
    ST_ILL   = 2'b11
  } led_state_e;

  // Width for a counter holding values 0..n-1. Returns at least 1 so that
  // degenerate parameters (for example no lockout) still give a legal vector.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_ctrl_chan.sv
// -----------------------------------------------------------------------------
// led_ctrl_chan
//   One key/LED channel. A one-cycle touch pulse steps the LED through
//   OFF -> ON -> BLINK -> OFF (or OFF <-> ON when blinking is disabled).
//   After an accepted touch the channel ignores further touches for LOCK_CYC
//   cycles. While in BLINK the LED toggles every BLINK_HALF cycles.
//
// Ports
//   clk        in  system clock
//   rst        in  synchronous reset, active-high
//   key_touch  in  one-cycle touch pulse for this channel
//   all_off    in  synchronous clear to OFF (touch in the same cycle dropped)
//   led        out registered LED drive, 1 = lit
//   state      out current channel state
// -----------------------------------------------------------------------------
module led_ctrl_chan
  import led_ctrl_pkg::*;
#(
  parameter int BLINK_EN   = 1,
  parameter int BLINK_HALF = 25_000_000,
  parameter int LOCK_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_touch,
  input  logic       all_off,
  output logic       led,
  output led_state_e state
);

  localparam int BW = cnt_w(BLINK_HALF);
  localparam int LW = cnt_w(LOCK_CYC + 1);

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCK_CYC);

  led_state_e    state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          led_q, led_d;
  logic          accept;
  logic          blink_wrap;

  assign accept     = key_touch && (lock_q == '0);
  assign blink_wrap = (blink_q == BLINK_LAST);

  // Next-state, lockout, blink timer and LED value.
  // NOTE: every output of this block is given a default first so that no
  // path through the case leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    lock_d  = (lock_q != '0) ? lock_q - 1'b1 : '0;
    blink_d = '0;
    led_d   = 1'b0;

    case (state_q)
      ST_OFF:   if (accept) state_d = ST_ON;
      ST_ON:    if (accept) state_d = (BLINK_EN != 0) ? ST_BLINK : ST_OFF;
      ST_BLINK: if (accept) state_d = ST_OFF;
      default:  state_d = ST_OFF;   // illegal code recovers in one edge
    endcase

    if (accept) lock_d = LOCK_LOAD;

    case (state_d)
      ST_ON:    led_d = 1'b1;
      ST_BLINK: begin
        if (state_q != ST_BLINK) begin
          // Entering BLINK: start lit with a fresh half-period.
          led_d   = 1'b1;
          blink_d = '0;
        end else begin
          blink_d = blink_wrap ? '0 : blink_q + 1'b1;
          led_d   = blink_wrap ? ~led_q : led_q;
        end
      end
      default:  led_d = 1'b0;
    endcase

    // Global clear overrides any touch seen this cycle.
    if (all_off) begin
      state_d = ST_OFF;
      lock_d  = '0;
      blink_d = '0;
      led_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      lock_q  <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign led   = led_q;
  assign state = state_q;

endmodule

// File: rtl/led_ctrl_fsm_multi.sv
// -----------------------------------------------------------------------------
// led_ctrl_fsm_multi
//   CH_NUM independent LED channels driven by one-cycle key touch pulses,
//   with a shared synchronous clear. Sits between the key pulse generators
//   and the board LED pins.
//
// Ports
//   clk        in  system clock
//   rst        in  synchronous reset, active-high
//   key_touch  in  [CH_NUM]   touch pulses, bit i -> channel i
//   all_off    in  synchronous clear: every channel to OFF
//   led        out [CH_NUM]   registered LED drive, 1 = lit
//   state_o    out [2*CH_NUM] channel i state at [2i+1:2i]
//                             (00 OFF, 01 ON, 10 BLINK)
// -----------------------------------------------------------------------------
module led_ctrl_fsm_multi
  import led_ctrl_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int BLINK_EN   = 1,
  parameter int BLINK_HALF = 25_000_000,
  parameter int LOCK_CYC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH_NUM-1:0]   key_touch,
  input  logic                all_off,
  output logic [CH_NUM-1:0]   led,
  output logic [2*CH_NUM-1:0] state_o
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    led_state_e ch_state;

    led_ctrl_chan #(
      .BLINK_EN   (BLINK_EN),
      .BLINK_HALF (BLINK_HALF),
      .LOCK_CYC   (LOCK_CYC)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .key_touch (key_touch[i]),
      .all_off   (all_off),
      .led       (led[i]),
      .state     (ch_state)
    );

    assign state_o[2*i +: 2] = ch_state;
  end

endmodule
